ld19_packet_framer: RTL and testbench
=====================================

LD19_PACKET_FRAMER -- requirements
Module: ld19_packet_framer

Interface
REQ-001 SHALL have port clk  in  1  system clock (12 MHz nominal).
REQ-002 SHALL have port reset  in  1  reset, synchronous, active-high.
REQ-003 SHALL have port byte_in  in  8  received UART byte.
REQ-004 SHALL have port byte_valid  in  1  one-cycle strobe: byte_in valid.
REQ-005 SHALL have port byte_error  in  1  one-cycle strobe: UART framing/null error, byte discarded.
REQ-006 SHALL have port pt_valid  out  1  point output valid.
REQ-007 SHALL have port pt_ready  in  1  sink accepts point.
REQ-008 SHALL have port pt_distance  out  16  point distance, mm.
REQ-009 SHALL have port pt_intensity  out  8  point intensity.
REQ-010 SHALL have port pt_index  out  4  point number 0..11.
REQ-011 SHALL have port pt_last  out  1  high with pt_index==11.
REQ-012 SHALL have ports speed, start_angle, end_angle, timestamp  out  16 each  header fields of the packet being emitted.
REQ-013 SHALL have port pkt_ok_count  out  16  CRC-good packets, wrapping.
REQ-014 SHALL have port crc_err_count  out  16  CRC-bad packets, saturating at 0xFFFF.
REQ-015 SHALL have port overrun_count  out  16  bytes dropped during EMIT or aborted packets, saturating.
REQ-016 SHALL have port busy  out  1  state != HUNT.

Function
REQ-017 Packet format SHALL be 47 bytes: 0x54, 0x2C, speed(2), start_angle(2), 12 x {dist LSB, dist MSB, intensity}, end_angle(2), timestamp(2), crc(1); multi-byte fields little-endian.
REQ-018 States SHALL be HUNT, VERLEN, BODY, CRC, EMIT; transitions occur only on byte_valid, except for EMIT.
REQ-019 HUNT: byte 0x54 -> VERLEN with CRC register = crc8(0x00, 0x54); other bytes are ignored.
REQ-020 VERLEN: 0x2C -> BODY, byte counter = 0; 0x54 -> remain in VERLEN with CRC re-seeded; any other byte -> HUNT.
REQ-021 BODY: accept 44 bytes (counter 0..43), update CRC, write fields/points to the staging buffer; counter==43 -> CRC.
REQ-022 CRC: a byte equal to the CRC register -> EMIT, latch header outputs, pkt_ok_count+1; a mismatch -> HUNT, crc_err_count+1.
REQ-023 CRC8 SHALL use poly 0x4D, init 0x00, MSB-first, no reflection, no final XOR, computed over bytes 0..45.
REQ-024 byte_error in VERLEN/BODY/CRC SHALL cause abort to HUNT with overrun_count+1; byte_error in HUNT SHALL be ignored.
REQ-025 EMIT: points SHALL be presented in index order 0..11; transfer occurs when pt_valid & pt_ready; outputs SHALL be stable while pt_valid & !pt_ready.
REQ-026 pt_valid SHALL rise the cycle after entering EMIT; with pt_ready held high, the 12 points SHALL take 12 consecutive cycles.
REQ-027 After the pt_last transfer, pt_valid SHALL deassert and state SHALL return to HUNT next cycle.
REQ-028 Any byte_valid while in EMIT, including the cycle of the final transfer, SHALL be dropped and SHALL increment overrun_count.
REQ-029 Header outputs SHALL hold their last latched value outside EMIT.
REQ-030 Counter increments SHALL be at most 1 per cycle; saturating counters SHALL hold at 0xFFFF.

Reset
REQ-031 reset SHALL force state HUNT and clear the CRC register and byte counter; all outputs and counters SHALL be 0, including pt_valid and busy.
REQ-032 reset asserted mid-BODY or mid-EMIT SHALL discard the partial packet; pt_valid SHALL be 0 on the cycle after reset is sampled.

Structure
REQ-033 Package ld19_pkg SHALL hold HDR_BYTE=0x54, VERLEN_BYTE=0x2C, BODY_LEN=44, NPOINTS=12, CRC_POLY=0x4D, the state encoding and the crc8 byte-update function.
REQ-034 Sub-module ld19_point_buf SHALL hold the 12x24-bit staging buffer: byte-addressed write port, index-addressed read port.

Verification
REQ-035 Valid packet (speed 0x0E10, start 0x1234, distances 100..111, intensity 200, end 0x1300, ts 0x7530, model CRC), pt_ready=1 -> 12 points in 12 cycles, pt_last at index 11, pkt_ok_count=1.
REQ-036 Same packet with the CRC byte XOR 0x01 -> no pt_valid, crc_err_count=1, busy=0 after the CRC byte.
REQ-037 Stream 0x54 0x54 0x2C followed by a valid body -> packet accepted, pkt_ok_count=1.
REQ-038 pt_ready low for 5 cycles at index 3 -> index 3 data held stable, no skipped or repeated index.
REQ-039 pt_ready=0 during EMIT while 3 bytes arrive -> overrun_count=3, then a valid packet is accepted.
REQ-040 reset at body byte 20, then a full valid packet -> counters 0 then 1, no stale points emitted.

Source files
------------

// File: rtl/ld19_pkg.sv
// LD19 lidar framer shared constants, types and CRC helper.
// Imported by the framer top and its point staging buffer.
package ld19_pkg;

  localparam logic [7:0] HDR_BYTE    = 8'h54;
  localparam logic [7:0] VERLEN_BYTE = 8'h2C;
  localparam int         BODY_LEN    = 44;
  localparam int         NPOINTS     = 12;
  localparam int         PT_BYTES    = 3;
  localparam logic [7:0] CRC_POLY    = 8'h4D;

  typedef enum logic [2:0] {
    ST_HUNT   = 3'd0,
    ST_VERLEN = 3'd1,
    ST_BODY   = 3'd2,
    ST_CRC    = 3'd3,
    ST_EMIT   = 3'd4
  } state_t;

  typedef struct packed {
    logic [15:0] speed;
    logic [15:0] start_angle;
    logic [15:0] end_angle;
    logic [15:0] timestamp;
  } ld19_hdr_t;

  // MSB-first CRC8, no reflection, no final XOR
  function automatic logic [7:0] crc8(
    input logic [7:0] crc,
    input logic [7:0] data
  );
    logic [7:0] c;
    c = crc ^ data;
    for (int i = 0; i < 8; i++) begin
      if (c[7]) c = {c[6:0], 1'b0} ^ CRC_POLY;
      else      c = {c[6:0], 1'b0};
    end
    return c;
  endfunction

endpackage

// File: rtl/ld19_point_buf.sv
// Staging buffer for the 12 points of one packet.
// Byte-addressed writes, point-indexed 24-bit reads.
module ld19_point_buf
  import ld19_pkg::*;
(
  input  logic        clk,
  input  logic        we,
  input  logic [5:0]  wr_addr,
  input  logic [7:0]  wr_data,
  input  logic [3:0]  rd_idx,
  output logic [23:0] rd_data
);

  logic [7:0] mem [NPOINTS*PT_BYTES];
  logic [5:0] base;

  always_ff @(posedge clk) begin
    if (we) mem[wr_addr] <= wr_data;
  end

  assign base = {2'b00, rd_idx} + {1'b0, rd_idx, 1'b0};

  // {intensity, dist MSB, dist LSB}
  assign rd_data = {mem[base + 6'd2],
                    mem[base + 6'd1],
                    mem[base]};

endmodule

// File: rtl/ld19_packet_framer.sv
// LD19 lidar packet framer: hunts, CRC-checks and
// streams the 12 points of each good packet.
module ld19_packet_framer
  import ld19_pkg::*;
(
  input  logic        clk,
  input  logic        reset,
  input  logic [7:0]  byte_in,
  input  logic        byte_valid,
  input  logic        byte_error,
  output logic        pt_valid,
  input  logic        pt_ready,
  output logic [15:0] pt_distance,
  output logic [7:0]  pt_intensity,
  output logic [3:0]  pt_index,
  output logic        pt_last,
  output logic [15:0] speed,
  output logic [15:0] start_angle,
  output logic [15:0] end_angle,
  output logic [15:0] timestamp,
  output logic [15:0] pkt_ok_count,
  output logic [15:0] crc_err_count,
  output logic [15:0] overrun_count,
  output logic        busy
);

  state_t     state, state_nxt;
  logic [7:0] crc, crc_nxt;
  logic [5:0] cnt, cnt_nxt;
  logic [3:0] idx_nxt;
  logic       pv_nxt;
  logic       stage_we, hdr_we;
  logic       ok_inc, err_inc, ovr_inc;
  logic       buf_we;
  logic [23:0] rd_data;
  ld19_hdr_t  hdr_s, hdr_q;

  always_comb begin
    state_nxt = state;
    crc_nxt   = crc;
    cnt_nxt   = cnt;
    idx_nxt   = pt_index;
    pv_nxt    = pt_valid;
    stage_we  = 1'b0;
    hdr_we    = 1'b0;
    ok_inc    = 1'b0;
    err_inc   = 1'b0;
    ovr_inc   = 1'b0;
    unique case (state)
      ST_HUNT: begin
        if (byte_valid && byte_in == HDR_BYTE) begin
          state_nxt = ST_VERLEN;
          crc_nxt   = crc8(8'h00, HDR_BYTE);
        end
      end
      ST_VERLEN: begin
        if (byte_error) begin
          state_nxt = ST_HUNT;
          ovr_inc   = 1'b1;
        end else if (byte_valid) begin
          if (byte_in == VERLEN_BYTE) begin
            state_nxt = ST_BODY;
            crc_nxt   = crc8(crc, byte_in);
            cnt_nxt   = 6'd0;
          end else if (byte_in == HDR_BYTE) begin
            crc_nxt   = crc8(8'h00, HDR_BYTE);
          end else begin
            state_nxt = ST_HUNT;
          end
        end
      end
      ST_BODY: begin
        if (byte_error) begin
          state_nxt = ST_HUNT;
          ovr_inc   = 1'b1;
        end else if (byte_valid) begin
          crc_nxt  = crc8(crc, byte_in);
          cnt_nxt  = cnt + 6'd1;
          stage_we = 1'b1;
          if (cnt == 6'(BODY_LEN - 1))
            state_nxt = ST_CRC;
        end
      end
      ST_CRC: begin
        if (byte_error) begin
          state_nxt = ST_HUNT;
          ovr_inc   = 1'b1;
        end else if (byte_valid) begin
          if (byte_in == crc) begin
            state_nxt = ST_EMIT;
            hdr_we    = 1'b1;
            ok_inc    = 1'b1;
            idx_nxt   = 4'd0;
          end else begin
            state_nxt = ST_HUNT;
            err_inc   = 1'b1;
          end
        end
      end
      ST_EMIT: begin
        ovr_inc = byte_valid;
        if (!pt_valid) begin
          pv_nxt = 1'b1;
        end else if (pt_ready) begin
          if (pt_index == 4'(NPOINTS - 1)) begin
            pv_nxt    = 1'b0;
            idx_nxt   = 4'd0;
            state_nxt = ST_HUNT;
          end else begin
            idx_nxt = pt_index + 4'd1;
          end
        end
      end
      default: state_nxt = ST_HUNT;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state    <= ST_HUNT;
      crc      <= 8'h00;
      cnt      <= 6'd0;
      pt_index <= 4'd0;
      pt_valid <= 1'b0;
    end else begin
      state    <= state_nxt;
      crc      <= crc_nxt;
      cnt      <= cnt_nxt;
      pt_index <= idx_nxt;
      pt_valid <= pv_nxt;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      hdr_s <= '0;
      hdr_q <= '0;
    end else begin
      if (stage_we) begin
        unique case (cnt)
          6'd0:    hdr_s.speed[7:0]        <= byte_in;
          6'd1:    hdr_s.speed[15:8]       <= byte_in;
          6'd2:    hdr_s.start_angle[7:0]  <= byte_in;
          6'd3:    hdr_s.start_angle[15:8] <= byte_in;
          6'd40:   hdr_s.end_angle[7:0]    <= byte_in;
          6'd41:   hdr_s.end_angle[15:8]   <= byte_in;
          6'd42:   hdr_s.timestamp[7:0]    <= byte_in;
          6'd43:   hdr_s.timestamp[15:8]   <= byte_in;
          default: ;
        endcase
      end
      if (hdr_we) hdr_q <= hdr_s;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      pkt_ok_count  <= 16'd0;
      crc_err_count <= 16'd0;
      overrun_count <= 16'd0;
    end else begin
      if (ok_inc)
        pkt_ok_count <= pkt_ok_count + 16'd1;
      if (err_inc && crc_err_count != 16'hFFFF)
        crc_err_count <= crc_err_count + 16'd1;
      if (ovr_inc && overrun_count != 16'hFFFF)
        overrun_count <= overrun_count + 16'd1;
    end
  end

  assign buf_we = stage_we && cnt >= 6'd4 && cnt <= 6'd39;

  ld19_point_buf u_buf (
    .clk     (clk),
    .we      (buf_we),
    .wr_addr (cnt - 6'd4),
    .wr_data (byte_in),
    .rd_idx  (pt_index),
    .rd_data (rd_data)
  );

  // buffer contents are meaningless outside a valid point
  assign pt_distance  = pt_valid ? rd_data[15:0]  : 16'd0;
  assign pt_intensity = pt_valid ? rd_data[23:16] : 8'd0;
  assign pt_last      = pt_valid && pt_index == 4'(NPOINTS - 1);

  assign speed       = hdr_q.speed;
  assign start_angle = hdr_q.start_angle;
  assign end_angle   = hdr_q.end_angle;
  assign timestamp   = hdr_q.timestamp;
  assign busy        = state != ST_HUNT;

endmodule

// File: tb/tb_ld19_packet_framer.sv
// Directed bench for ld19_packet_framer.
// Builds one reference packet and replays it in scenarios.
module tb_ld19_packet_framer;

  logic        clk;
  logic        reset;
  logic [7:0]  byte_in;
  logic        byte_valid;
  logic        byte_error;
  logic        pt_valid;
  logic        pt_ready;
  logic [15:0] pt_distance;
  logic [7:0]  pt_intensity;
  logic [3:0]  pt_index;
  logic        pt_last;
  logic [15:0] speed;
  logic [15:0] start_angle;
  logic [15:0] end_angle;
  logic [15:0] timestamp;
  logic [15:0] pkt_ok_count;
  logic [15:0] crc_err_count;
  logic [15:0] overrun_count;
  logic        busy;

  int n_chk  = 0;
  int n_pass = 0;
  logic [7:0] pkt [47];

  ld19_packet_framer dut (
    .clk           (clk),
    .reset         (reset),
    .byte_in       (byte_in),
    .byte_valid    (byte_valid),
    .byte_error    (byte_error),
    .pt_valid      (pt_valid),
    .pt_ready      (pt_ready),
    .pt_distance   (pt_distance),
    .pt_intensity  (pt_intensity),
    .pt_index      (pt_index),
    .pt_last       (pt_last),
    .speed         (speed),
    .start_angle   (start_angle),
    .end_angle     (end_angle),
    .timestamp     (timestamp),
    .pkt_ok_count  (pkt_ok_count),
    .crc_err_count (crc_err_count),
    .overrun_count (overrun_count),
    .busy          (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(
    input string       tag,
    input logic [31:0] got,
    input logic [31:0] exp
  );
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h want 0x%0h",
                  tag, got, exp);
  endtask

  // bit-serial LFSR form of the CRC8
  function automatic logic [7:0] crc_ref(input int n);
    logic [7:0] c;
    logic       fb;
    c = 8'h00;
    for (int k = 0; k < n; k++)
      for (int b = 7; b >= 0; b--) begin
        fb = c[7] ^ pkt[k][b];
        c  = {c[6:0], 1'b0} ^ (fb ? 8'h4D : 8'h00);
      end
    return c;
  endfunction

  task automatic build_pkt();
    pkt[0] = 8'h54; pkt[1] = 8'h2C;
    pkt[2] = 8'h10; pkt[3] = 8'h0E;
    pkt[4] = 8'h34; pkt[5] = 8'h12;
    for (int i = 0; i < 12; i++) begin
      pkt[6 + 3*i] = 8'(100 + i);
      pkt[7 + 3*i] = 8'h00;
      pkt[8 + 3*i] = 8'd200;
    end
    pkt[42] = 8'h00; pkt[43] = 8'h13;
    pkt[44] = 8'h30; pkt[45] = 8'h75;
    pkt[46] = crc_ref(46);
  endtask

  task automatic do_reset();
    reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
  endtask

  task automatic send_byte(input logic [7:0] b);
    byte_in    = b;
    byte_valid = 1'b1;
    @(posedge clk); #1;
    byte_valid = 1'b0;
  endtask

  task automatic send_prefix(input int n);
    for (int i = 0; i < n; i++) send_byte(pkt[i]);
  endtask

  task automatic send_pkt(input logic [7:0] crc_xor);
    send_prefix(46);
    send_byte(pkt[46] ^ crc_xor);
  endtask

  task automatic pulse_error();
    byte_error = 1'b1;
    @(posedge clk); #1;
    byte_error = 1'b0;
  endtask

  task automatic drain(
    input int stall_at,
    input int stall_len,
    input bit timing
  );
    int got, cyc, first, last, st;
    logic [15:0] held;
    got = 0; cyc = 0; first = -1;
    last = -1; st = 0; held = '0;
    pt_ready = 1'b1;
    while (got < 12 && cyc < 300) begin
      if (pt_valid) begin
        if (first < 0) first = cyc;
        if (got == stall_at && st < stall_len) begin
          if (st == 0) held = pt_distance;
          else begin
            chk("hold_dist", pt_distance, held);
            chk("hold_idx", pt_index, stall_at);
          end
          pt_ready = 1'b0;
          st++;
        end else begin
          pt_ready = 1'b1;
          chk("pt_idx", pt_index, got);
          chk("pt_dist", pt_distance, 100 + got);
          chk("pt_int", pt_intensity, 200);
          chk("pt_last", pt_last, got == 11);
          got++;
          last = cyc;
        end
      end
      @(posedge clk); #1;
      cyc++;
    end
    chk("n_points", got, 12);
    if (timing) begin
      chk("pv_latency", first, 1);
      chk("pt_span", last - first, 11);
    end
    chk("pv_drop", pt_valid, 0);
    chk("busy_end", busy, 0);
    pt_ready = 1'b1;
  endtask

  initial begin
    int seen;
    reset      = 1'b1;
    byte_in    = 8'h00;
    byte_valid = 1'b0;
    byte_error = 1'b0;
    pt_ready   = 1'b1;
    build_pkt();
    repeat (3) @(posedge clk);
    #1 reset = 1'b0;

    chk("rst_busy", busy, 0);
    chk("rst_pv", pt_valid, 0);
    chk("rst_ok", pkt_ok_count, 0);
    chk("rst_crcerr", crc_err_count, 0);
    chk("rst_ovr", overrun_count, 0);
    chk("rst_speed", speed, 0);
    chk("rst_dist", pt_distance, 0);

    // good packet, sink always ready
    send_pkt(8'h00);
    chk("emit_busy", busy, 1);
    drain(-1, 0, 1);
    chk("ok_1", pkt_ok_count, 1);
    chk("speed", speed, 16'h0E10);
    chk("start", start_angle, 16'h1234);
    chk("end", end_angle, 16'h1300);
    chk("ts", timestamp, 16'h7530);

    // corrupted CRC byte
    send_pkt(8'h01);
    chk("bad_busy", busy, 0);
    chk("crc_err_1", crc_err_count, 1);
    seen = 0;
    repeat (5) begin
      if (pt_valid) seen++;
      @(posedge clk); #1;
    end
    chk("bad_no_pv", seen, 0);
    chk("bad_ok", pkt_ok_count, 1);
    chk("hdr_hold", speed, 16'h0E10);

    // duplicate header byte
    do_reset();
    send_byte(8'h54);
    send_pkt(8'h00);
    drain(-1, 0, 1);
    chk("dup_ok", pkt_ok_count, 1);

    // backpressure at index 3
    send_pkt(8'h00);
    drain(3, 5, 0);
    chk("stall_ok", pkt_ok_count, 2);

    // bytes arriving during EMIT
    do_reset();
    send_pkt(8'h00);
    pt_ready = 1'b0;
    send_byte(8'h54);
    send_byte(8'h2C);
    send_byte(8'hAA);
    chk("ovr_3", overrun_count, 3);
    chk("ovr_busy", busy, 1);
    drain(-1, 0, 0);
    send_pkt(8'h00);
    drain(-1, 0, 1);
    chk("ovr_ok", pkt_ok_count, 2);
    chk("ovr_keep", overrun_count, 3);

    // byte_error: ignored in HUNT, aborts mid-packet
    do_reset();
    pulse_error();
    chk("err_hunt", overrun_count, 0);
    send_prefix(10);
    pulse_error();
    chk("err_abort", overrun_count, 1);
    chk("err_busy", busy, 0);
    send_pkt(8'h00);
    drain(-1, 0, 1);
    chk("err_ok", pkt_ok_count, 1);

    // reset in the middle of the body
    do_reset();
    send_prefix(22);
    chk("mid_busy", busy, 1);
    do_reset();
    chk("mid_pv", pt_valid, 0);
    chk("mid_idle", busy, 0);
    chk("mid_ok0", pkt_ok_count, 0);
    send_pkt(8'h00);
    drain(-1, 0, 1);
    chk("mid_ok1", pkt_ok_count, 1);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
